// File: rtl/display_arbiter.sv
// Shares the 8-digit seven-segment display between the clock, alarm and timer drivers.
// The source is chosen from the base mode and the overrides; every switch forces a short dark gap.
module display_arbiter #(
  parameter int unsigned OVERLAY_CYCLES = 200_000_000,
  parameter int unsigned BLANK_CYCLES   = 1000,
  parameter int unsigned FLASH_BIT      = 24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] clk_segm,
  input  logic [7:0] clk_dign,
  input  logic [7:0] alm_segm,
  input  logic [7:0] alm_dign,
  input  logic [7:0] tmr_segm,
  input  logic [7:0] tmr_dign,
  input  logic       btn_mode,
  input  logic       alarm_busy,
  input  logic       is_uart_set,
  input  logic       is_alarm_going_off,
  output logic [7:0] segm,
  output logic [7:0] dign,
  output logic [1:0] active_src,
  output logic [2:0] mode_led
);

  localparam int unsigned OVL_W = (OVERLAY_CYCLES > 0) ? $clog2(OVERLAY_CYCLES + 1) : 1;
  localparam int unsigned BLK_W = (BLANK_CYCLES > 0) ? $clog2(BLANK_CYCLES + 1) : 1;
  localparam int unsigned FLS_W = FLASH_BIT + 1;

  localparam logic [OVL_W-1:0] OVL_LOAD = OVL_W'(OVERLAY_CYCLES);
  localparam logic [BLK_W-1:0] BLK_LOAD = BLK_W'(BLANK_CYCLES);

  typedef enum logic [1:0] {
    SRC_CLOCK = 2'b00,
    SRC_ALARM = 2'b01,
    SRC_TIMER = 2'b10
  } src_t;

  src_t             base_mode, base_next;
  src_t             sel_q, sel_next;
  logic [OVL_W-1:0] ovl_cnt, ovl_next;
  logic [BLK_W-1:0] blank_cnt, blank_next;
  logic [FLS_W-1:0] flash_cnt, flash_next;
  logic             wake_q;

  logic             btn_ok;
  logic             wake_rise;
  logic             overlay;
  logic             flash_off;
  logic [7:0]       src_segm, src_dign;
  logic [7:0]       segm_next, dign_next;
  logic [1:0]       active_next;
  logic [2:0]       led_next;

  always_comb begin
    btn_ok    = btn_mode & ~is_alarm_going_off & ~alarm_busy;
    wake_rise = is_alarm_going_off & ~wake_q;
    overlay   = (ovl_cnt != '0);

    base_next = base_mode;
    if (alarm_busy) begin
      base_next = SRC_ALARM;
    end else if (btn_ok) begin
      case (base_mode)
        SRC_CLOCK: base_next = SRC_ALARM;
        SRC_ALARM: base_next = SRC_TIMER;
        default:   base_next = SRC_CLOCK;
      endcase
    end

    // A UART set wins over a same-cycle mode press: the press still advances the mode.
    ovl_next = ovl_cnt;
    if (wake_rise) begin
      ovl_next = '0;
    end else if (is_uart_set) begin
      ovl_next = OVL_LOAD;
    end else if (btn_ok) begin
      ovl_next = '0;
    end else if (overlay) begin
      ovl_next = ovl_cnt - 1'b1;
    end

    if (is_alarm_going_off) begin
      sel_next = SRC_CLOCK;
    end else if (alarm_busy || overlay) begin
      sel_next = SRC_ALARM;
    end else begin
      sel_next = base_mode;
    end

    if (sel_next != sel_q) begin
      blank_next = BLK_LOAD;
    end else if (blank_cnt != '0) begin
      blank_next = blank_cnt - 1'b1;
    end else begin
      blank_next = blank_cnt;
    end

    // Cleared on the wake edge so the first flash half-period is lit.
    flash_next = wake_rise ? '0 : flash_cnt + 1'b1;
    flash_off  = is_alarm_going_off & flash_next[FLASH_BIT];

    case (sel_next)
      SRC_ALARM: begin src_segm = alm_segm; src_dign = alm_dign; end
      SRC_TIMER: begin src_segm = tmr_segm; src_dign = tmr_dign; end
      default:   begin src_segm = clk_segm; src_dign = clk_dign; end
    endcase

    // Outputs are derived from the post-edge blank count so the dark gap is exactly BLANK_CYCLES long.
    if (blank_next != '0) begin
      segm_next   = '1;
      dign_next   = '1;
      active_next = 2'b11;
    end else begin
      segm_next   = src_segm;
      dign_next   = flash_off ? '1 : src_dign;
      active_next = sel_next;
    end

    led_next = {base_next == SRC_TIMER, base_next == SRC_ALARM, base_next == SRC_CLOCK};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      base_mode  <= SRC_CLOCK;
      sel_q      <= SRC_CLOCK;
      ovl_cnt    <= '0;
      blank_cnt  <= '0;
      flash_cnt  <= '0;
      wake_q     <= 1'b0;
      segm       <= '1;
      dign       <= '1;
      active_src <= 2'b00;
      mode_led   <= 3'b001;
    end else begin
      base_mode  <= base_next;
      sel_q      <= sel_next;
      ovl_cnt    <= ovl_next;
      blank_cnt  <= blank_next;
      flash_cnt  <= flash_next;
      wake_q     <= is_alarm_going_off;
      segm       <= segm_next;
      dign       <= dign_next;
      active_src <= active_next;
      mode_led   <= led_next;
    end
  end

endmodule

// File: tb/tb_display_arbiter.sv
// Self-checking bench for display_arbiter: directed scenarios plus randomized mode/UART traffic
// compared with a cycle-level behavioural model of the display selection rules.
module tb_display_arbiter;

  localparam int OVL = 20;
  localparam int BLK = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] clk_segm = 8'h11, clk_dign = 8'h11;
  logic [7:0] alm_segm = 8'h22, alm_dign = 8'h22;
  logic [7:0] tmr_segm = 8'h33, tmr_dign = 8'h33;
  logic       btn_mode = 1'b0;
  logic       alarm_busy = 1'b0;
  logic       is_uart_set = 1'b0;
  logic       is_alarm_going_off = 1'b0;
  logic [7:0] segm, dign;
  logic [1:0] active_src;
  logic [2:0] mode_led;

  int checks = 0;
  int passes = 0;

  display_arbiter #(
    .OVERLAY_CYCLES(OVL),
    .BLANK_CYCLES  (BLK),
    .FLASH_BIT     (3)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .clk_segm          (clk_segm),
    .clk_dign          (clk_dign),
    .alm_segm          (alm_segm),
    .alm_dign          (alm_dign),
    .tmr_segm          (tmr_segm),
    .tmr_dign          (tmr_dign),
    .btn_mode          (btn_mode),
    .alarm_busy        (alarm_busy),
    .is_uart_set       (is_uart_set),
    .is_alarm_going_off(is_alarm_going_off),
    .segm              (segm),
    .dign              (dign),
    .active_src        (active_src),
    .mode_led          (mode_led)
  );

  always #5 clk = ~clk;

  wire [20:0] got = {segm, dign, active_src, mode_led};

  // Source s (0 clock, 1 alarm, 2 timer) drives 8'h11 * (s + 1).
  function automatic logic [7:0] val(int s);
    return 8'(8'h11 * (s + 1));
  endfunction

  function automatic logic [20:0] mk(logic [7:0] sg, logic [7:0] dg, logic [1:0] src, int mode);
    return {sg, dg, src, 3'(1 << mode)};
  endfunction

  function automatic logic [20:0] shown(int s, int mode);
    return mk(val(s), val(s), 2'(s), mode);
  endfunction

  function automatic logic [20:0] dark(int mode);
    return mk(8'hFF, 8'hFF, 2'b11, mode);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [20:0] exp;
    rst = 1'b1;
    step();
    step();
    exp = mk(8'hFF, 8'hFF, 2'b00, 0);
    checks++;
    if (got !== exp) $display("FAIL reset_state got=%h exp=%h", got, exp);
    else passes++;
    rst = 1'b0;
    step();
    exp = shown(0, 0);
    checks++;
    if (got !== exp) $display("FAIL reset_release got=%h exp=%h", got, exp);
    else passes++;
  endtask

  task automatic test_mode_cycle();
    logic [20:0] exp;
    int nxt;
    for (int p = 0; p < 3; p++) begin
      nxt = (p + 1) % 3;
      for (int k = 1; k <= 6; k++) begin
        btn_mode = (k == 1);
        step();
        btn_mode = 1'b0;
        if (k == 1)        exp = shown(p, nxt);
        else if (k <= 1 + BLK) exp = dark(nxt);
        else               exp = shown(nxt, nxt);
        checks++;
        if (got !== exp) $display("FAIL mode_cycle p=%0d k=%0d got=%h exp=%h", p, k, got, exp);
        else passes++;
      end
    end
  endtask

  task automatic test_overlay();
    logic [20:0] exp;
    int second, last_alarm;
    for (int run = 0; run < 2; run++) begin
      second = (run == 0) ? 0 : 11;
      last_alarm = ((run == 0) ? 1 : second) + OVL;
      for (int k = 1; k <= last_alarm + BLK + 2; k++) begin
        is_uart_set = (k == 1) || (k == second);
        step();
        is_uart_set = 1'b0;
        if (k == 1)                        exp = shown(0, 0);
        else if (k <= 1 + BLK)             exp = dark(0);
        else if (k <= last_alarm)          exp = shown(1, 0);
        else if (k <= last_alarm + BLK)    exp = dark(0);
        else                               exp = shown(0, 0);
        checks++;
        if (got !== exp) $display("FAIL overlay run=%0d k=%0d got=%h exp=%h", run, k, got, exp);
        else passes++;
      end
    end
  endtask

  task automatic test_alarm_busy();
    logic [20:0] exp;
    alarm_busy = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      btn_mode = (k == 6);
      step();
      btn_mode = 1'b0;
      exp = (k <= BLK) ? dark(1) : shown(1, 1);
      checks++;
      if (got !== exp) $display("FAIL alarm_busy k=%0d got=%h exp=%h", k, got, exp);
      else passes++;
    end
    alarm_busy = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      step();
      exp = shown(1, 1);
      checks++;
      if (got !== exp) $display("FAIL busy_release k=%0d got=%h exp=%h", k, got, exp);
      else passes++;
    end
  endtask

  task automatic test_wake();
    logic [20:0] exp;
    btn_mode = 1'b1;
    step();
    btn_mode = 1'b0;
    repeat (6) step();
    exp = shown(2, 2);
    checks++;
    if (got !== exp) $display("FAIL wake_setup got=%h exp=%h", got, exp);
    else passes++;
    is_alarm_going_off = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      btn_mode = (k == 12);
      step();
      btn_mode = 1'b0;
      if (k <= BLK) exp = dark(2);
      else exp = mk(8'h11, (((k - 1) >> 3) & 1) != 0 ? 8'hFF : 8'h11, 2'b00, 2);
      checks++;
      if (got !== exp) $display("FAIL wake_flash k=%0d got=%h exp=%h", k, got, exp);
      else passes++;
    end
    is_alarm_going_off = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      step();
      exp = (k <= BLK) ? dark(2) : shown(2, 2);
      checks++;
      if (got !== exp) $display("FAIL wake_fall k=%0d got=%h exp=%h", k, got, exp);
      else passes++;
    end
  endtask

  task automatic test_reset_mid();
    logic [20:0] exp;
    is_uart_set = 1'b1;
    step();
    is_uart_set = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp = mk(8'hFF, 8'hFF, 2'b00, 0);
    checks++;
    if (got !== exp) $display("FAIL reset_mid got=%h exp=%h", got, exp);
    else passes++;
    for (int k = 1; k <= 4; k++) begin
      step();
      exp = shown(0, 0);
      checks++;
      if (got !== exp) $display("FAIL reset_mid_after k=%0d got=%h exp=%h", k, got, exp);
      else passes++;
    end
  endtask

  task automatic test_random();
    logic [20:0] exp;
    int base, ovl_left, disp_src, blank_left, want;
    rst = 1'b1;
    step();
    rst = 1'b0;
    base = 0; ovl_left = 0; disp_src = 0; blank_left = 0;
    for (int k = 1; k <= 300; k++) begin
      btn_mode    = ($urandom_range(0, 9) == 0);
      is_uart_set = ($urandom_range(0, 29) == 0);
      step();
      // The display follows the overlay if one is running, else the base mode, with a dark gap on every change.
      want = (ovl_left > 0) ? 1 : base;
      if (want != disp_src) begin
        disp_src = want;
        blank_left = BLK;
      end else if (blank_left > 0) begin
        blank_left--;
      end
      if (btn_mode) base = (base + 1) % 3;
      if (is_uart_set) ovl_left = OVL;
      else if (btn_mode) ovl_left = 0;
      else if (ovl_left > 0) ovl_left--;
      btn_mode = 1'b0;
      is_uart_set = 1'b0;
      exp = (blank_left > 0) ? dark(base) : shown(disp_src, base);
      checks++;
      if (got !== exp) $display("FAIL random k=%0d got=%h exp=%h", k, got, exp);
      else passes++;
    end
  endtask

  initial begin
    test_reset();
    test_mode_cycle();
    test_overlay();
    test_alarm_busy();
    test_wake();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
